// File: rtl/dec_unbinder_pipe_if.sv
// Stream bundle for the unbinder: input side (bound HV, shift, tag) and
// output side (unbound HV, tag), each with its own valid/ready pair.
interface dec_unbinder_pipe_if #(
    parameter int unsigned HV_DIM = 1024,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned SHW    = $clog2(HV_DIM)
);
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] in_hv;
    logic [SHW-1:0]    in_shift;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] out_hv;
    logic [TAG_W-1:0]  out_tag;

    // Producer/consumer environment around the block.
    modport master (
        output in_valid, in_hv, in_shift, in_tag, out_ready,
        input  in_ready, out_valid, out_hv, out_tag
    );

    // The unbinder itself.
    modport slave (
        input  in_valid, in_hv, in_shift, in_tag, out_ready,
        output in_ready, out_valid, out_hv, out_tag
    );
endinterface

// File: rtl/dec_unbinder_pipe.sv
// Decoder-side unbinder: rotates a bound hypervector right by the feature's
// shift amount, undoing the encoder's left rotation. Built as a pipelined
// logarithmic barrel rotator; each stage resolves BITS_PER_STAGE shift bits.
// The whole pipe advances or freezes together (no bubble collapsing).
module dec_unbinder_pipe #(
    parameter int unsigned HV_DIM         = 1024,
    parameter int unsigned SHW            = $clog2(HV_DIM),
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_W          = 6
) (
    input logic                clk,
    input logic                rst,
    dec_unbinder_pipe_if.slave bus
);
    localparam int unsigned NUM_STAGES = (SHW + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    // Shift width padded up to a whole number of stage fields.
    localparam int unsigned PSW = NUM_STAGES * BITS_PER_STAGE;

    if (HV_DIM < 2 || (HV_DIM & (HV_DIM - 1)) != 0) begin : g_dim_check
        $error("dec_unbinder_pipe: HV_DIM must be a power of two >= 2");
    end
    if (BITS_PER_STAGE < 1) begin : g_bps_check
        $error("dec_unbinder_pipe: BITS_PER_STAGE must be at least 1");
    end

    // Circular right rotation; amt is always below HV_DIM here.
    function automatic logic [HV_DIM-1:0] rotr(input logic [HV_DIM-1:0] x,
                                               input int unsigned       amt);
        return HV_DIM'({x, x} >> amt);
    endfunction

    logic                  adv;

    logic [NUM_STAGES-1:0] vld_q, vld_d;
    logic [HV_DIM-1:0]     hv_q  [NUM_STAGES];
    logic [HV_DIM-1:0]     hv_d  [NUM_STAGES];
    // Remaining (not yet applied) shift bits, kept right-aligned so the
    // field a stage consumes always sits in the low BITS_PER_STAGE bits.
    logic [PSW-1:0]        sh_q  [NUM_STAGES];
    logic [PSW-1:0]        sh_d  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_q [NUM_STAGES];
    logic [TAG_W-1:0]      tag_d [NUM_STAGES];

    // Global advance: the pipe moves unless the last stage holds data that
    // downstream is refusing.
    always_comb begin
        adv = !vld_q[NUM_STAGES-1] || bus.out_ready;
    end

    // Next-stage values: stage k rotates by (field k) << (k*BITS_PER_STAGE).
    always_comb begin
        vld_d[0] = bus.in_valid;
        sh_d[0]  = PSW'(bus.in_shift) >> BITS_PER_STAGE;
        tag_d[0] = bus.in_tag;
        hv_d[0]  = rotr(bus.in_hv, 32'(PSW'(bus.in_shift) & PSW'((1 << BITS_PER_STAGE) - 1)));
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            sh_d[k]  = sh_q[k-1] >> BITS_PER_STAGE;
            tag_d[k] = tag_q[k-1];
            hv_d[k]  = rotr(hv_q[k-1],
                            32'(sh_q[k-1][BITS_PER_STAGE-1:0]) << (k * BITS_PER_STAGE));
        end
    end

    // Pipeline registers: synchronous clear, otherwise load-all or hold-all.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                hv_q[k]  <= '0;
                sh_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                hv_q[k]  <= hv_d[k];
                sh_q[k]  <= sh_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // Handshake and output data straight from the last stage.
    always_comb begin
        bus.in_ready  = adv;
        bus.out_valid = vld_q[NUM_STAGES-1];
        bus.out_hv    = hv_q[NUM_STAGES-1];
        bus.out_tag   = tag_q[NUM_STAGES-1];
    end
endmodule
